// File: rtl/huedeon_cmd_seq.sv
// huedeon_cmd_seq: command-list sequencer for the HuedeonGPU register write port.
//
// The host pushes 32-bit command words into a show-ahead FIFO. The sequencer decodes
// WRITE_REG / DRAW / SWAP headers into single-cycle GPU register writes, waits for the
// raster to finish after each draw, and performs vblank-synchronised buffer swaps.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_push, i_push_data   command word push; o_full / o_level / o_overflow report FIFO state
//   o_gpu_cs, o_gpu_wr_*  registered GPU register write port (cs == wr_enable)
//   i_gpu_status          bit0 = busy, bit1 = done
//   i_vblank              vertical blank level, synchronous to i_clk
//   o_idle, o_error       sequencer idle with empty FIFO / sticky unknown-opcode error
//   o_front_buf           displayed buffer (0 = BUF0)
//   o_draw_count          completed draws, o_frame_count completed swaps (both wrap)
module huedeon_cmd_seq #(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter logic [17:0] BUF0_BASE     = 18'd0,
    parameter logic [17:0] BUF1_BASE     = 18'd76800,
    parameter int unsigned START_TIMEOUT = 15
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_push,
    input  logic [31:0]                   i_push_data,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic                          o_gpu_cs,
    output logic                          o_gpu_wr_enable,
    output logic [31:0]                   o_gpu_wr_address,
    output logic [31:0]                   o_gpu_wr_data,
    input  logic [31:0]                   i_gpu_status,
    input  logic                          i_vblank,
    output logic                          o_idle,
    output logic                          o_error,
    output logic                          o_front_buf,
    output logic [15:0]                   o_draw_count,
    output logic [15:0]                   o_frame_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;

    localparam logic [7:0] OpWriteReg = 8'h01;
    localparam logic [7:0] OpDraw     = 8'h02;
    localparam logic [7:0] OpSwap     = 8'h03;

    localparam logic [31:0] RegDrawStrobe = 32'd2;
    localparam logic [31:0] RegDrawBase   = 32'd18;
    localparam logic [31:0] RegDispBase   = 32'd19;

    localparam logic [31:0] Base0 = {14'd0, BUF0_BASE};
    localparam logic [31:0] Base1 = {14'd0, BUF1_BASE};

    typedef enum logic [3:0] {
        StInitDraw,
        StInitDisp,
        StIdle,
        StWrArg,
        StDrawIssue,
        StDrawWaitStart,
        StDrawWaitEnd,
        StSwapWaitVb,
        StSwapDisp,
        StSwapDraw,
        StError
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and pointers
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          in_error;
    logic          push_ok;
    logic          pop;
    logic [31:0]   head;

    // Sequencer state
    logic          wr_en_q, wr_en_d;
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [7:0]    reg_q, reg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   draw_cnt_q, draw_cnt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          front_q, front_d;
    logic          vb_q;

    logic          busy;
    logic          unused_status;

    assign busy          = i_gpu_status[0];
    assign unused_status = ^i_gpu_status[31:1];

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (AW + 1)'(FIFO_DEPTH));
    assign in_error   = (state_q == StError);
    // Pushes while in ERROR are discarded without flagging overflow.
    assign push_ok    = i_push && !fifo_full && !in_error;
    assign head       = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (i_push && fifo_full && !in_error);
        if (in_error) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop) begin
                level_d = level_q + (AW + 1)'(1);
            end else if (pop && !push_ok) begin
                level_d = level_q - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_d       = reg_q;
        cnt_d       = cnt_q;
        draw_cnt_d  = draw_cnt_q;
        frame_cnt_d = frame_cnt_q;
        front_d     = front_q;

        unique case (state_q)
            StInitDraw: begin
                wr_en_d   = 1'b1;
                wr_addr_d = RegDrawBase;
                wr_data_d = Base1;
                state_d   = StInitDisp;
            end
            StInitDisp: begin
                wr_en_d   = 1'b1;
                wr_addr_d = RegDispBase;
                wr_data_d = Base0;
                state_d   = StIdle;
            end
            StIdle: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    reg_d = head[7:0];
                    case (head[31:24])
                        OpWriteReg: state_d = StWrArg;
                        OpDraw:     state_d = StDrawIssue;
                        OpSwap:     state_d = StSwapWaitVb;
                        default:    state_d = StError;
                    endcase
                end
            end
            StWrArg: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = {24'd0, reg_q};
                    wr_data_d = head;
                    state_d   = StIdle;
                end
            end
            StDrawIssue: begin
                wr_en_d   = 1'b1;
                wr_addr_d = RegDrawStrobe;
                wr_data_d = 32'd1;
                cnt_d     = '0;
                state_d   = StDrawWaitStart;
            end
            StDrawWaitStart: begin
                // cnt_q == 0 is the cycle the strobe is visible; busy is not yet meaningful.
                if ((cnt_q != '0) && busy) begin
                    state_d = StDrawWaitEnd;
                end else if (cnt_q == CW'(START_TIMEOUT)) begin
                    // Raster never started: degenerate triangle, still counts as a draw.
                    state_d    = StIdle;
                    draw_cnt_d = draw_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDrawWaitEnd: begin
                if (!busy) begin
                    state_d    = StIdle;
                    draw_cnt_d = draw_cnt_q + 16'd1;
                end
            end
            StSwapWaitVb: begin
                if (i_vblank && !vb_q) begin
                    state_d = StSwapDisp;
                end
            end
            StSwapDisp: begin
                wr_en_d   = 1'b1;
                wr_addr_d = RegDispBase;
                wr_data_d = front_q ? Base0 : Base1;
                state_d   = StSwapDraw;
            end
            StSwapDraw: begin
                wr_en_d     = 1'b1;
                wr_addr_d   = RegDrawBase;
                wr_data_d   = front_q ? Base1 : Base0;
                front_d     = !front_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = StIdle;
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StInitDraw;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            reg_q       <= '0;
            cnt_q       <= '0;
            draw_cnt_q  <= '0;
            frame_cnt_q <= '0;
            front_q     <= 1'b0;
            vb_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            reg_q       <= reg_d;
            cnt_q       <= cnt_d;
            draw_cnt_q  <= draw_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            front_q     <= front_d;
            vb_q        <= i_vblank;
        end
    end

    assign o_full           = fifo_full;
    assign o_level          = level_q;
    assign o_overflow       = overflow_q;
    assign o_gpu_cs         = wr_en_q;
    assign o_gpu_wr_enable  = wr_en_q;
    assign o_gpu_wr_address = wr_addr_q;
    assign o_gpu_wr_data    = wr_data_q;
    assign o_idle           = (state_q == StIdle) && fifo_empty;
    assign o_error          = in_error;
    assign o_front_buf      = front_q;
    assign o_draw_count     = draw_cnt_q;
    assign o_frame_count    = frame_cnt_q;

endmodule
